// File: rtl/fifo_thr.sv
// fifo_thr: parametrised synchronous FIFO with run-time almost-full /
// almost-empty thresholds, exact occupancy count, per-side error pulses and
// pause/can_pop flow-control outputs. Producer and consumer share one clock.
//
// Optional feature macro: FIFO_FWFT_EN
//   undefined : registered read, rd_data/rd_valid update the edge a pop is
//               accepted; rd_data holds between pops.
//   defined   : first-word-fall-through, rd_data shows the head word
//               combinationally, rd_valid = !empty, rd_en consumes it.
//
// Parameters: DATA_W (word width), DEPTH (power of two, >= 2).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wr_en, wr_data        push request / data
//   rd_en                 pop request (FWFT: acknowledge of displayed word)
//   af_thr, ae_thr        almost-full / almost-empty thresholds, 0..DEPTH
//   rd_data, rd_valid     read word and qualifier
//   count                 entries held, 0..DEPTH
//   full, empty           count==DEPTH / count==0
//   almost_full           count >= af_thr
//   almost_empty          count <= ae_thr
//   wr_error, rd_error    one-cycle pulse after a rejected push / pop
//   error                 wr_error | rd_error
//   pause                 full | almost_full
//   can_pop               !empty
module fifo_thr #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW:0]       af_thr,
    input  logic [AW:0]       ae_thr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              wr_error,
    output logic              rd_error,
    output logic              error,
    output logic              pause,
    output logic              can_pop
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q,  count_d;
    logic        full_q,   full_d;
    logic        empty_q,  empty_d;
    logic        af_q,     af_d;
    logic        ae_q,     ae_d;
    logic        wr_err_q, wr_err_d;
    logic        rd_err_q, rd_err_d;
    logic        push_acc;
    logic        pop_acc;

    // Accept decisions use the registered flags, so a push into a full FIFO
    // is rejected even when a pop frees a slot in the same cycle.
    always_comb begin
        push_acc = wr_en && !full_q;
        pop_acc  = rd_en && !empty_q;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_acc};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_acc};
        // Pointers carry a wrap bit, so the modulo-2*DEPTH difference is the
        // exact occupancy, including the full case.
        count_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (count_d == DEPTH_C);
        empty_d  = (count_d == '0);
        af_d     = (count_d >= af_thr);
        ae_d     = (count_d <= ae_thr);
        wr_err_d = wr_en && full_q;
        rd_err_d = rd_en && empty_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Storage is not reset; writes are blocked during the reset cycle.
    always_ff @(posedge clk) begin
        if (!reset && push_acc) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    assign rd_data  = mem[rd_ptr_q[AW-1:0]];
    assign rd_valid = !empty_q;
`else
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= pop_acc;
            if (pop_acc) begin
                rd_data_q <= mem[rd_ptr_q[AW-1:0]];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign wr_error     = wr_err_q;
    assign rd_error     = rd_err_q;
    assign error        = wr_err_q | rd_err_q;
    assign pause        = full_q | af_q;
    assign can_pop      = !empty_q;

endmodule

// File: tb/tb_fifo_thr.sv
// Directed self-checking bench for fifo_thr (DEPTH=8, DATA_W=6, registered
// read). Inputs change 1 ns after a rising edge; outputs are checked there.
module tb_fifo_thr;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [5:0] wr_data;
    logic       rd_en;
    logic [3:0] af_thr;
    logic [3:0] ae_thr;
    logic [5:0] rd_data;
    logic       rd_valid;
    logic [3:0] count;
    logic       full, empty, almost_full, almost_empty;
    logic       wr_error, rd_error, error, pause, can_pop;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    fifo_thr #(.DATA_W(6), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .af_thr(af_thr), .ae_thr(ae_thr),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .wr_error(wr_error),
        .rd_error(rd_error), .error(error), .pause(pause), .can_pop(can_pop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input int unsigned c);
        chk({tag, " count"}, 32'(count), 32'(c));
        chk({tag, " full"}, 32'(full), 32'(c == 8));
        chk({tag, " empty"}, 32'(empty), 32'(c == 0));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(c >= 32'(af_thr)));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(c <= 32'(ae_thr)));
        chk({tag, " pause"}, 32'(pause), 32'((c == 8) || (c >= 32'(af_thr))));
        chk({tag, " can_pop"}, 32'(can_pop), 32'(c != 0));
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        af_thr = 4'd6; ae_thr = 4'd1;
        step(); step();
        reset = 1'b0;
        chk_flags("reset", 0);
        chk("reset rd_data", 32'(rd_data), 32'h0);
        chk("reset rd_valid", 32'(rd_valid), 32'h0);
        chk("reset wr_error", 32'(wr_error), 32'h0);
        chk("reset rd_error", 32'(rd_error), 32'h0);
        chk("reset error", 32'(error), 32'h0);

        // Fill 0x01..0x08; fixed expectations for the threshold crossings.
        wr_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            wr_data = 6'(i);
            step();
            chk_flags("fill", i);
            chk("fill ae", 32'(almost_empty), 32'(i == 1));
            chk("fill af", 32'(almost_full), 32'(i >= 6));
        end
        wr_data = 6'h09;
        step();
        chk("overflow wr_error", 32'(wr_error), 32'h1);
        chk("overflow error", 32'(error), 32'h1);
        chk("overflow count", 32'(count), 32'h8);
        wr_en = 1'b0;
        step();
        chk("overflow pulse end", 32'(wr_error), 32'h0);

        // Drain 8 in order, then one pop from empty.
        rd_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("drain rd_data", 32'(rd_data), 32'(i));
            chk("drain rd_valid", 32'(rd_valid), 32'h1);
            chk_flags("drain", 8 - i);
        end
        step();
        chk("underflow rd_error", 32'(rd_error), 32'h1);
        chk("underflow error", 32'(error), 32'h1);
        chk("underflow rd_valid", 32'(rd_valid), 32'h0);
        chk("underflow empty", 32'(empty), 32'h1);
        rd_en = 1'b0;
        step();
        chk("underflow pulse end", 32'(rd_error), 32'h0);
        chk("hold rd_data", 32'(rd_data), 32'h08);

        // Bring count to 3, then 20 cycles of simultaneous push+pop.
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 6'(8'h10 + i);
            step();
        end
        chk("stream pre count", 32'(count), 32'h3);
        rd_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wr_data = 6'(8'h13 + k);
            step();
            chk("stream rd_data", 32'(rd_data), 32'(8'h10 + k));
            chk("stream rd_valid", 32'(rd_valid), 32'h1);
            chk("stream count", 32'(count), 32'h3);
            chk("stream error", 32'(error), 32'h0);
        end
        wr_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stream tail rd_data", 32'(rd_data), 32'(8'h24 + k));
        end
        rd_en = 1'b0;
        step();
        chk_flags("stream end", 0);

        // Full, then push+pop: pop wins, push rejected.
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = 6'(8'h30 + i);
            step();
        end
        chk_flags("refill", 8);
        rd_en = 1'b1; wr_data = 6'h3F;
        step();
        chk("full pp count", 32'(count), 32'h7);
        chk("full pp wr_error", 32'(wr_error), 32'h1);
        chk("full pp rd_error", 32'(rd_error), 32'h0);
        chk("full pp rd_data", 32'(rd_data), 32'h30);
        chk("full pp full", 32'(full), 32'h0);
        wr_en = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step();
            chk("full pp drain", 32'(rd_data), 32'(8'h30 + i));
        end
        rd_en = 1'b0;
        step();
        chk_flags("full pp end", 0);

        // Empty, then push+pop: push wins, pop rejected.
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 6'h2A;
        step();
        chk("empty pp count", 32'(count), 32'h1);
        chk("empty pp rd_error", 32'(rd_error), 32'h1);
        chk("empty pp wr_error", 32'(wr_error), 32'h0);
        chk("empty pp rd_valid", 32'(rd_valid), 32'h0);
        chk("empty pp rd_data hold", 32'(rd_data), 32'h37);
        wr_en = 1'b0;
        step();
        chk("w2r rd_data", 32'(rd_data), 32'h2A);
        chk("w2r rd_valid", 32'(rd_valid), 32'h1);
        chk("w2r count", 32'(count), 32'h0);
        rd_en = 1'b0;

        // Threshold change with no traffic at count 4.
        wr_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wr_data = 6'(i);
            step();
        end
        wr_en = 1'b0;
        chk("thr pre af", 32'(almost_full), 32'h0);
        af_thr = 4'd4;
        step();
        chk("thr af", 32'(almost_full), 32'h1);
        chk("thr pause", 32'(pause), 32'h1);
        chk("thr count", 32'(count), 32'h4);
        ae_thr = 4'd4;
        step();
        chk("thr ae", 32'(almost_empty), 32'h1);
        af_thr = 4'd8;
        step();
        chk("thr af off", 32'(almost_full), 32'h0);

        // Reset mid-stream with a push request present.
        reset = 1'b1; wr_en = 1'b1; wr_data = 6'h15;
        step();
        chk("midreset count", 32'(count), 32'h0);
        chk("midreset empty", 32'(empty), 32'h1);
        chk("midreset almost_empty", 32'(almost_empty), 32'h1);
        chk("midreset rd_data", 32'(rd_data), 32'h0);
        reset = 1'b0; wr_en = 1'b0;
        step();
        chk("post reset count", 32'(count), 32'h0);
        chk("post reset can_pop", 32'(can_pop), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_thr.md
# fifo_thr

Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds, an exact occupancy count, per-side error pulses and pause/can_pop flow-control outputs. It is the generalised successor to the fixed-depth 4/16-entry FIFO and sits between a producer and a consumer in the same clock domain. Depth and width are free parameters. Thresholds are run-time inputs, so the same block serves every buffering point in the datapath.

## Interface
- DATA_W, 6, data word width in bits (>=1)
- DEPTH, 8, number of entries; power of two, >=2; AW = log2(DEPTH) is derived locally
- clk  in  1  clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- wr_en  in  1  push request
- wr_data  in  DATA_W  push data
- rd_en  in  1  pop request
- af_thr  in  AW+1  almost-full threshold, 0..DEPTH
- ae_thr  in  AW+1  almost-empty threshold, 0..DEPTH
- rd_data  out  DATA_W  popped / head word
- rd_valid  out  1  rd_data qualifier
- count  out  AW+1  entries held, 0..DEPTH
- full, empty  out  1  count==DEPTH / count==0
- almost_full  out  1  count >= af_thr
- almost_empty  out  1  count <= ae_thr
- wr_error, rd_error  out  1  one-cycle rejected push / pop pulse
- error  out  1  wr_error | rd_error (combinational OR of the registered flags)
- pause  out  1  full | almost_full, producer throttle
- can_pop  out  1  !empty

## Operation
- Storage: DEPTH x DATA_W array, not reset. Pointers are AW+1 bits; the low AW bits index the array, and the MSB is a wrap bit.
- Push is accepted iff wr_en && !full, where full is the registered value this cycle. Pop is accepted iff rd_en && !empty.
- Rejected push: wr_error=1 next cycle; memory and wr_ptr unchanged. Rejected pop: rd_error=1 next cycle.
- count_next = count + push_acc - pop_acc. Both accepted: count unchanged, both pointers advance.
- full, empty, almost_full and almost_empty are registered from count_next and the current thresholds. Flags are exact, with no one-cycle lag.
- Flags are recomputed every cycle. A threshold change takes effect at the next edge even without traffic.
- Simultaneous push+pop when full: the pop is accepted and the push is rejected (wr_error). When empty: the push is accepted and the pop is rejected (rd_error).
- Pointers wrap modulo 2*DEPTH. All arithmetic is unsigned AW+1 bits, and count = wr_ptr - rd_ptr.
- Reset values: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, rd_data 0, rd_valid 0, wr_error 0, rd_error 0.
- Reset mid-operation discards all contents at that edge. Requests in the reset cycle are ignored.

## Timing
- Default (registered read): on an accepted pop at edge N, rd_data = head word and rd_valid=1 after edge N. rd_valid lasts 1 cycle per pop; back-to-back pops give back-to-back valids.
- When there is no pop, rd_data holds its last value and rd_valid=0.
- Write-to-read: a word pushed at edge N can be popped at edge N+1, since empty deasserts after edge N.
- Error pulses are high for exactly the cycle after the offending edge.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through mode.
  - rd_data = mem[rd_ptr] combinationally, and rd_valid = !empty.
  - rd_en acknowledges the displayed word, which is consumed at that edge.
  - Read latency 0. rd_data is undefined while empty.
- FIFO_FWFT_EN undefined: registered read as described under Timing.

## Test plan
- Reset, DEPTH=8, af_thr=6, ae_thr=1 -> empty=1, almost_empty=1, count=0, all other outputs 0.
- Push 0x01..0x08 on consecutive cycles -> count 1..8; almost_empty drops at count 2; almost_full and pause rise at count 6; full at count 8. A 9th push -> wr_error=1 for one cycle, count stays 8.
- Pop 8 from full -> rd_data 0x01..0x08 in order with rd_valid each cycle (FWFT: same sequence at zero latency). A 9th pop -> rd_error=1, rd_valid=0.
- Simultaneous push+pop for 20 cycles at count=3 -> count stays 3, pointers wrap, data order preserved, no errors.
- Push+pop when full -> count 7, wr_error=1. Push+pop when empty -> count 1, rd_error=1.
- At count=4, change af_thr from 6 to 4 with no traffic -> almost_full=1 after the next edge. Assert reset mid-stream -> count=0 and empty=1 after that edge.
